shift_chunk_pipe: RTL and testbench

//   Pipelined, parametrised chunk shifter. Successor to the fixed 50-bit, 5-bit-chunk combinational right shifter.

---
 rtl/shift_chunk_pipe_if.sv | 35 +++
 rtl/shift_chunk_pipe.sv | 139 +++++++++++++
 tb/tb_shift_chunk_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_chunk_pipe_if.sv
// rtl/shift_chunk_pipe_if.sv - beat-level bus of the pipelined chunk shifter
//
// Purpose: groups the input beat (word, shift, mode, fill), the output beat
// (shifted word, error flag) and the error counter of shift_chunk_pipe.
// Modports:
//   master : upstream/downstream side (drives in_*, out_ready)
//   slave  : the shifter (drives in_ready, out_*, err_count)

interface shift_chunk_pipe_if #(
    parameter int CHUNK  = 5,
    parameter int NCHUNK = 10,
    parameter int SHW    = 4
) ();
    logic                      in_valid;
    logic                      in_ready;
    logic [CHUNK*NCHUNK-1:0]   in_data;
    logic [SHW-1:0]            in_shift;
    logic [1:0]                in_mode;
    logic [CHUNK-1:0]          in_fill;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHUNK*NCHUNK-1:0]   out_data;
    logic                      out_err;
    logic [7:0]                err_count;

    modport master (
        output in_valid, in_data, in_shift, in_mode, in_fill, out_ready,
        input  in_ready, out_valid, out_data, out_err, err_count
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_mode, in_fill, out_ready,
        output in_ready, out_valid, out_data, out_err, err_count
    );
endinterface

// File: rtl/shift_chunk_pipe.sv
// rtl/shift_chunk_pipe.sv - 2-stage valid/ready chunk shifter (shr/shl/ror)
//
// Purpose: shifts a word of NCHUNK chunks of CHUNK bits by a whole number of
// chunks. Stage 1 captures the beat and decodes the effective shift and error;
// stage 2 holds the shifted result. err_count saturates at 255.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : shift_chunk_pipe_if.slave (in_* beat, out_* beat, err_count)

module shift_chunk_pipe #(
    parameter int CHUNK  = 5,
    parameter int NCHUNK = 10,
    parameter int SHW    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_chunk_pipe_if.slave bus
);
    localparam int DW = CHUNK * NCHUNK;

    localparam logic [1:0] MODE_SHR = 2'b00;
    localparam logic [1:0] MODE_SHL = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    // Stage 1
    logic             v1_q;
    logic [DW-1:0]    data1_q;
    logic [CHUNK-1:0] fill1_q;
    logic [1:0]       mode1_q;
    logic [SHW-1:0]   s1_q;
    logic             err1_q;
    logic [SHW-1:0]   s1_d;
    logic             err1_d;

    // Stage 2
    logic             v2_q;
    logic [DW-1:0]    out_data_q;
    logic             out_err_q;
    logic [DW-1:0]    res_d;

    logic [7:0]       err_count_q;
    logic [7:0]       err_count_d;

    logic adv1;
    logic adv2;
    logic accept;

    assign adv2   = ~v2_q | bus.out_ready;
    assign adv1   = ~v1_q | adv2;
    assign accept = bus.in_valid & adv1;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v2_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_count = err_count_q;

    // Rotation is reduced modulo NCHUNK up front so stage 2 only ever sees
    // s < NCHUNK for ror; shr/shl keep the raw amount and flag it if too big.
    always_comb begin
        s1_d   = bus.in_shift;
        err1_d = 1'b0;
        case (bus.in_mode)
            MODE_SHR, MODE_SHL: err1_d = (int'(bus.in_shift) >= NCHUNK);
            MODE_ROR:           s1_d   = SHW'(int'(bus.in_shift) % NCHUNK);
            default:            err1_d = 1'b1;
        endcase
    end

    // Chunk mux: illegal shr/shl fall through to the fill pattern for every
    // chunk; the reserved mode passes the word through untouched.
    always_comb begin
        int src;
        res_d = '0;
        src   = 0;
        for (int k = 0; k < NCHUNK; k++) begin
            res_d[k*CHUNK +: CHUNK] = fill1_q;
            case (mode1_q)
                MODE_SHR: begin
                    src = k + int'(s1_q);
                    if (!err1_q && src < NCHUNK)
                        res_d[k*CHUNK +: CHUNK] = data1_q[src*CHUNK +: CHUNK];
                end
                MODE_SHL: begin
                    src = k - int'(s1_q);
                    if (!err1_q && src >= 0)
                        res_d[k*CHUNK +: CHUNK] = data1_q[src*CHUNK +: CHUNK];
                end
                MODE_ROR: begin
                    src = k + int'(s1_q);
                    if (src >= NCHUNK)
                        src = src - NCHUNK;
                    res_d[k*CHUNK +: CHUNK] = data1_q[src*CHUNK +: CHUNK];
                end
                default: res_d[k*CHUNK +: CHUNK] = data1_q[k*CHUNK +: CHUNK];
            endcase
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (v2_q && bus.out_ready && out_err_q && err_count_q != 8'hFF)
            err_count_d = err_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            data1_q     <= '0;
            fill1_q     <= '0;
            mode1_q     <= '0;
            s1_q        <= '0;
            err1_q      <= 1'b0;
            v2_q        <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (adv1)
                v1_q <= bus.in_valid;
            if (accept) begin
                data1_q <= bus.in_data;
                fill1_q <= bus.in_fill;
                mode1_q <= bus.in_mode;
                s1_q    <= s1_d;
                err1_q  <= err1_d;
            end
            if (adv2)
                v2_q <= v1_q;
            // Result only moves when stage 2 advances, so it holds under stall.
            if (adv2 && v1_q) begin
                out_data_q <= res_d;
                out_err_q  <= err1_q;
            end
            err_count_q <= err_count_d;
        end
    end
endmodule

// File: tb/tb_shift_chunk_pipe.sv
// tb/tb_shift_chunk_pipe.sv - directed self-checking bench for shift_chunk_pipe

module tb_shift_chunk_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    shift_chunk_pipe_if #(.CHUNK(5), .NCHUNK(10), .SHW(4)) bus ();

    shift_chunk_pipe #(.CHUNK(5), .NCHUNK(10), .SHW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_cnt      = 0;

    logic [49:0] d_seq;

    function automatic logic [49:0] pk(input logic [4:0] c9, c8, c7, c6, c5,
                                       input logic [4:0] c4, c3, c2, c1, c0);
        return {c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.out_data !== 50'h0) begin
            tests_failed++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data);
        end
        tests_run++;
        if (bus.out_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err);
        end
        tests_run++;
        if (bus.err_count !== 8'd0) begin
            tests_failed++; $display("FAIL reset_err_count: got %0d expected 0", bus.err_count);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        bus.out_ready = 1'b1;
    endtask

    // One beat through an idle pipe with out_ready held high.
    task automatic test_single(input string name, input logic [49:0] data,
                               input logic [3:0] shift, input logic [1:0] mode,
                               input logic [4:0] fill, input logic [49:0] exp_data,
                               input logic exp_err);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = data;
        bus.in_shift  = shift;
        bus.in_mode   = mode;
        bus.in_fill   = fill;
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL %s in_ready: got %b expected 1", name, bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL %s early_valid: got %b expected 0", name, bus.out_valid);
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++; $display("FAIL %s latency: got out_valid %b expected 1", name, bus.out_valid);
        end
        tests_run++;
        if (bus.out_data !== exp_data) begin
            tests_failed++; $display("FAIL %s data: got %h expected %h", name, bus.out_data, exp_data);
        end
        tests_run++;
        if (bus.out_err !== exp_err) begin
            tests_failed++; $display("FAIL %s err: got %b expected %b", name, bus.out_err, exp_err);
        end
        if (exp_err && exp_cnt < 255)
            exp_cnt++;
        tick();
        tests_run++;
        if (bus.err_count !== 8'(exp_cnt)) begin
            tests_failed++; $display("FAIL %s err_count: got %0d expected %0d", name, bus.err_count, exp_cnt);
        end
    endtask

    task automatic test_shr();
        test_single("shr3",  d_seq, 4'd3, 2'b00, 5'h1F,
                    pk(5'h1F,5'h1F,5'h1F,5'd9,5'd8,5'd7,5'd6,5'd5,5'd4,5'd3), 1'b0);
        test_single("shr9",  d_seq, 4'd9, 2'b00, 5'h1F,
                    pk(5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'd9), 1'b0);
        test_single("shr0",  d_seq, 4'd0, 2'b00, 5'h1F, d_seq, 1'b0);
    endtask

    task automatic test_shl();
        test_single("shl2",  d_seq, 4'd2, 2'b01, 5'h0A,
                    pk(5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0,5'h0A,5'h0A), 1'b0);
        test_single("shl9",  d_seq, 4'd9, 2'b01, 5'h1F,
                    pk(5'd0,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F,5'h1F), 1'b0);
    endtask

    task automatic test_ror();
        test_single("ror13", d_seq, 4'd13, 2'b10, 5'h11,
                    pk(5'd2,5'd1,5'd0,5'd9,5'd8,5'd7,5'd6,5'd5,5'd4,5'd3), 1'b0);
        test_single("ror15", d_seq, 4'd15, 2'b10, 5'h00,
                    pk(5'd4,5'd3,5'd2,5'd1,5'd0,5'd9,5'd8,5'd7,5'd6,5'd5), 1'b0);
    endtask

    task automatic test_illegal();
        test_single("shr10", d_seq, 4'd10, 2'b00, 5'h15, {10{5'h15}}, 1'b1);
        test_single("shl15", d_seq, 4'd15, 2'b01, 5'h03, {10{5'h03}}, 1'b1);
        test_single("mode3", d_seq, 4'd3,  2'b11, 5'h1F, d_seq, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [49:0] bd [8];
        int          tx;
        int          rx;
        logic        prev_stall;
        logic [49:0] prev_data;
        logic        saw_low;
        for (int i = 0; i < 8; i++)
            bd[i] = {10{5'(i * 3 + 1)}};
        tx = 0; rx = 0; prev_stall = 1'b0; prev_data = '0; saw_low = 1'b0;
        bus.in_shift = 4'd0;
        bus.in_mode  = 2'b00;
        bus.in_fill  = 5'h00;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            bus.out_ready = !(cyc >= 3 && cyc <= 6);
            bus.in_valid  = (tx < 8);
            if (tx < 8)
                bus.in_data = bd[tx];
            #1;
            if (!bus.in_ready)
                saw_low = 1'b1;
            if (prev_stall) begin
                tests_run++;
                if (bus.out_data !== prev_data) begin
                    tests_failed++; $display("FAIL b2b_stall_hold: got %h expected %h", bus.out_data, prev_data);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                if (bus.out_data !== bd[rx]) begin
                    tests_failed++; $display("FAIL b2b_order beat %0d: got %h expected %h", rx, bus.out_data, bd[rx]);
                end
                rx++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            if (bus.in_valid && bus.in_ready)
                tx++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tests_run++;
        if (rx != 8) begin
            tests_failed++; $display("FAIL b2b_delivered: got %0d expected 8", rx);
        end
        tests_run++;
        if (!saw_low) begin
            tests_failed++; $display("FAIL b2b_in_ready_low: got never-low expected low");
        end
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_no_dup: got out_valid %b expected 0", bus.out_valid);
        end
    endtask

    task automatic stream_err(input int n);
        bus.out_ready = 1'b1;
        bus.in_mode   = 2'b11;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < n; i++)
            tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_saturation();
        stream_err(254 - exp_cnt);
        tests_run++;
        if (bus.err_count !== 8'd254) begin
            tests_failed++; $display("FAIL sat_254: got %0d expected 254", bus.err_count);
        end
        stream_err(1);
        tests_run++;
        if (bus.err_count !== 8'd255) begin
            tests_failed++; $display("FAIL sat_255: got %0d expected 255", bus.err_count);
        end
        stream_err(5);
        tests_run++;
        if (bus.err_count !== 8'd255) begin
            tests_failed++; $display("FAIL sat_sticky: got %0d expected 255", bus.err_count);
        end
    endtask

    task automatic test_reset_midflight();
        logic seen;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d_seq;
        bus.in_shift  = 4'd1;
        bus.in_mode   = 2'b00;
        bus.in_fill   = 5'h00;
        tick();
        tick();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rst_mid_valid: got %b expected 0", bus.out_valid);
        end
        tests_run++;
        if (bus.err_count !== 8'd0) begin
            tests_failed++; $display("FAIL rst_mid_count: got %0d expected 0", bus.err_count);
        end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.out_valid)
                seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++; $display("FAIL rst_mid_ghost: got stale beat expected none");
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_shift  = '0;
        bus.in_mode   = '0;
        bus.in_fill   = '0;
        bus.out_ready = 1'b0;
        d_seq = pk(5'd9,5'd8,5'd7,5'd6,5'd5,5'd4,5'd3,5'd2,5'd1,5'd0);
        test_reset();
        test_shr();
        test_shl();
        test_ror();
        test_illegal();
        test_back_to_back();
        test_saturation();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
